// File: rtl/sn76489_det_pkg.sv
// sn76489_det_pkg: shared widths, channel count and types for the PSG period/peak detector
package sn76489_det_pkg;
  localparam int NUM_CH = 4;
  localparam int CNT_W = 10;
  localparam int MAG_W = 8;
  typedef enum logic {IDLE, MEAS} det_state_e;
  typedef logic [0:CNT_W-1] cnt_t;
  typedef logic [0:MAG_W-1] mag_t;
endpackage

// File: rtl/sn76489_det_chan.sv
// sn76489_det_chan: one-channel rising-edge period and peak detector; in clk,res_i,clock_en_i,ch_i; out det_counter_o,det_magnitude_o,det_done_o (+det_high_o when SN76489_DET_DUTY_EN)
module sn76489_det_chan import sn76489_det_pkg::*; #(
  parameter mag_t THRESH = 8'd0,
  parameter cnt_t CNT_MAX = 10'd1023
) (
  input  logic clk,
  input  logic res_i,
  input  logic clock_en_i,
  input  mag_t ch_i,
  output cnt_t det_counter_o,
  output mag_t det_magnitude_o,
`ifdef SN76489_DET_DUTY_EN
  output cnt_t det_high_o,
`endif
  output logic det_done_o
);
  det_state_e state;
  logic prev_high, high, rise, report;
  cnt_t cnt, cnt_inc;
  mag_t peak, peak_max;
  always_comb begin
    high = ch_i > THRESH;
    rise = high && !prev_high;
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt_t'(cnt + 1'b1);
    peak_max = (ch_i > peak) ? ch_i : peak;
    report = clock_en_i && state == MEAS && (rise || cnt_inc == CNT_MAX);
  end
  always_ff @(posedge clk)
    if (res_i) begin
      state <= IDLE;
      prev_high <= 1'b0;
      cnt <= '0;
      peak <= '0;
      det_counter_o <= '0;
      det_magnitude_o <= '0;
      det_done_o <= 1'b0;
    end else begin
      det_done_o <= report;
      if (clock_en_i) begin
        prev_high <= high;
        cnt <= rise ? cnt_t'(1) : cnt_inc;
        peak <= rise ? ch_i : peak_max;
        state <= rise ? MEAS : report ? IDLE : state;
      end
      if (report) begin
        det_counter_o <= rise ? cnt : CNT_MAX;
        det_magnitude_o <= rise ? peak : peak_max;
      end
    end
`ifdef SN76489_DET_DUTY_EN
  cnt_t hi_cnt, hi_inc;
  always_comb hi_inc = (high && hi_cnt != CNT_MAX) ? cnt_t'(hi_cnt + 1'b1) : hi_cnt;
  always_ff @(posedge clk)
    if (res_i) begin
      hi_cnt <= '0;
      det_high_o <= '0;
    end else begin
      if (clock_en_i) hi_cnt <= rise ? cnt_t'(1) : hi_inc;
      if (report) det_high_o <= rise ? hi_cnt : hi_inc;
    end
`endif
endmodule

// File: rtl/sn76489_det.sv
// sn76489_det: four-channel PSG period/peak detector; in clk,res_i,clock_en_i,ch_i[4]; out det_counter_o[4],det_magnitude_o[4],det_done_o[4] (+det_high_o[4] when SN76489_DET_DUTY_EN)
module sn76489_det import sn76489_det_pkg::*; #(
  parameter mag_t THRESH = 8'd0,
  parameter cnt_t CNT_MAX = 10'd1023
) (
  input  logic clk,
  input  logic res_i,
  input  logic clock_en_i,
  input  mag_t ch_i [NUM_CH],
  output cnt_t det_counter_o [NUM_CH],
  output mag_t det_magnitude_o [NUM_CH],
`ifdef SN76489_DET_DUTY_EN
  output cnt_t det_high_o [NUM_CH],
`endif
  output logic det_done_o [NUM_CH]
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sn76489_det_chan #(.THRESH(THRESH), .CNT_MAX(CNT_MAX)) u_chan (
      .clk(clk),
      .res_i(res_i),
      .clock_en_i(clock_en_i),
      .ch_i(ch_i[i]),
      .det_counter_o(det_counter_o[i]),
      .det_magnitude_o(det_magnitude_o[i]),
`ifdef SN76489_DET_DUTY_EN
      .det_high_o(det_high_o[i]),
`endif
      .det_done_o(det_done_o[i])
    );
  end
endmodule

// File: tb/tb_sn76489_det.sv
// tb_sn76489_det: directed self-checking bench for sn76489_det (default and THRESH=50 instances)
module tb_sn76489_det;
  import sn76489_det_pkg::*;
  logic clk = 1'b0;
  logic res_i = 1'b1;
  logic clock_en_i = 1'b0;
  mag_t ch [NUM_CH];
  cnt_t cnt_o [NUM_CH];
  mag_t mag_o [NUM_CH];
  logic done_o [NUM_CH];
  cnt_t cnt2 [NUM_CH];
  mag_t mag2 [NUM_CH];
  logic done2 [NUM_CH];
`ifdef SN76489_DET_DUTY_EN
  cnt_t high_o [NUM_CH];
  cnt_t high2 [NUM_CH];
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sn76489_det dut (
    .clk(clk), .res_i(res_i), .clock_en_i(clock_en_i), .ch_i(ch),
    .det_counter_o(cnt_o), .det_magnitude_o(mag_o),
`ifdef SN76489_DET_DUTY_EN
    .det_high_o(high_o),
`endif
    .det_done_o(done_o)
  );
  sn76489_det #(.THRESH(8'd50)) dut2 (
    .clk(clk), .res_i(res_i), .clock_en_i(clock_en_i), .ch_i(ch),
    .det_counter_o(cnt2), .det_magnitude_o(mag2),
`ifdef SN76489_DET_DUTY_EN
    .det_high_o(high2),
`endif
    .det_done_o(done2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    res_i = 1'b1;
    clock_en_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) ch[c] = '0;
    tick();
    tick();
    res_i = 1'b0;
    clock_en_i = 1'b1;
  endtask
  task automatic test_reset();
    res_i = 1'b1;
    clock_en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NUM_CH; c++) ch[c] = mag_t'($urandom);
      tick();
    end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (cnt_o[c] !== 10'd0 || mag_o[c] !== 8'd0 || done_o[c] !== 1'b0) begin
        errors++;
        $display("FAIL reset ch%0d cnt=%0d mag=%0d done=%b expected 0/0/0", c, cnt_o[c], mag_o[c], done_o[c]);
      end
`ifdef SN76489_DET_DUTY_EN
      checks++;
      if (high_o[c] !== 10'd0) begin
        errors++;
        $display("FAIL reset_high ch%0d got %0d expected 0", c, high_o[c]);
      end
`endif
    end
    res_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) ch[c] = '0;
    tick();
    for (int c = 0; c < NUM_CH; c++) ch[c] = 8'd200;
    tick();
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (done_o[c] !== 1'b0) begin
        errors++;
        $display("FAIL reset_first_edge ch%0d done=%b expected 0", c, done_o[c]);
      end
    end
  endtask
  task automatic test_square();
    do_reset();
    for (int k = 0; k < 50; k++) begin
      ch[0] = (k % 10 < 5) ? 8'd200 : 8'd0;
      tick();
      checks++;
      if (done_o[0] !== (k >= 10 && k % 10 == 0)) begin
        errors++;
        $display("FAIL square_done tick%0d got %b expected %b", k, done_o[0], k >= 10 && k % 10 == 0);
      end
      if (k >= 10 && k % 10 == 0) begin
        checks++;
        if (cnt_o[0] !== 10'd10 || mag_o[0] !== 8'd200) begin
          errors++;
          $display("FAIL square_val tick%0d cnt=%0d mag=%0d expected 10/200", k, cnt_o[0], mag_o[0]);
        end
`ifdef SN76489_DET_DUTY_EN
        checks++;
        if (high_o[0] !== 10'd5) begin
          errors++;
          $display("FAIL square_high tick%0d got %0d expected 5", k, high_o[0]);
        end
`endif
      end
    end
  endtask
  task automatic test_slow_ce();
    int t;
    logic exp;
    do_reset();
    for (int c = 0; c < 196; c++) begin
      clock_en_i = (c % 4 == 0);
      t = c / 4;
      ch[1] = clock_en_i ? ((t % 16 < 8) ? 8'd15 : 8'd0) : ((c % 2 == 1) ? 8'd255 : 8'd0);
      exp = clock_en_i && t >= 16 && t % 16 == 0;
      tick();
      checks++;
      if (done_o[1] !== exp) begin
        errors++;
        $display("FAIL slow_done clk%0d got %b expected %b", c, done_o[1], exp);
      end
      if (exp) begin
        checks++;
        if (cnt_o[1] !== 10'd16 || mag_o[1] !== 8'd15) begin
          errors++;
          $display("FAIL slow_val clk%0d cnt=%0d mag=%0d expected 16/15", c, cnt_o[1], mag_o[1]);
        end
`ifdef SN76489_DET_DUTY_EN
        checks++;
        if (high_o[1] !== 10'd8) begin
          errors++;
          $display("FAIL slow_high clk%0d got %0d expected 8", c, high_o[1]);
        end
`endif
      end
    end
    clock_en_i = 1'b1;
  endtask
  task automatic test_timeout();
    do_reset();
    ch[2] = 8'd100;
    tick();
    ch[2] = 8'd0;
    for (int k = 1; k <= 1072; k++) begin
      tick();
      checks++;
      if (done_o[2] !== (k == 1022)) begin
        errors++;
        $display("FAIL timeout_done tick%0d got %b expected %b", k, done_o[2], k == 1022);
      end
      if (k == 1022) begin
        checks++;
        if (cnt_o[2] !== 10'd1023 || mag_o[2] !== 8'd100) begin
          errors++;
          $display("FAIL timeout_val cnt=%0d mag=%0d expected 1023/100", cnt_o[2], mag_o[2]);
        end
`ifdef SN76489_DET_DUTY_EN
        checks++;
        if (high_o[2] !== 10'd1) begin
          errors++;
          $display("FAIL timeout_high got %0d expected 1", high_o[2]);
        end
`endif
      end
    end
    ch[2] = 8'd100;
    tick();
    checks++;
    if (done_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rearm done=%b expected 0", done_o[2]);
    end
    ch[2] = 8'd0;
    for (int k = 0; k < 5; k++) tick();
    ch[2] = 8'd100;
    tick();
    checks++;
    if (done_o[2] !== 1'b1 || cnt_o[2] !== 10'd6 || mag_o[2] !== 8'd100) begin
      errors++;
      $display("FAIL timeout_next done=%b cnt=%0d mag=%0d expected 1/6/100", done_o[2], cnt_o[2], mag_o[2]);
    end
  endtask
  task automatic test_noise();
    mag_t seq [7] = '{8'd70, 8'd40, 8'd90, 8'd60, 8'd0, 8'd0, 8'd70};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      ch[3] = seq[k];
      tick();
      checks++;
      if (done_o[3] !== (k == 6)) begin
        errors++;
        $display("FAIL noise_done idx%0d got %b expected %b", k, done_o[3], k == 6);
      end
    end
    checks++;
    if (cnt_o[3] !== 10'd6 || mag_o[3] !== 8'd90) begin
      errors++;
      $display("FAIL noise_val cnt=%0d mag=%0d expected 6/90", cnt_o[3], mag_o[3]);
    end
`ifdef SN76489_DET_DUTY_EN
    checks++;
    if (high_o[3] !== 10'd4) begin
      errors++;
      $display("FAIL noise_high got %0d expected 4", high_o[3]);
    end
`endif
  endtask
  task automatic test_thresh();
    mag_t seq [10] = '{8'd0, 8'd40, 8'd0, 8'd40, 8'd0, 8'd60, 8'd40, 8'd0, 8'd40, 8'd60};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ch[3] = seq[k];
      tick();
      checks++;
      if (done2[3] !== (k == 9)) begin
        errors++;
        $display("FAIL thresh_done idx%0d got %b expected %b", k, done2[3], k == 9);
      end
    end
    checks++;
    if (cnt2[3] !== 10'd4 || mag2[3] !== 8'd60) begin
      errors++;
      $display("FAIL thresh_val cnt=%0d mag=%0d expected 4/60", cnt2[3], mag2[3]);
    end
`ifdef SN76489_DET_DUTY_EN
    checks++;
    if (high2[3] !== 10'd1) begin
      errors++;
      $display("FAIL thresh_high got %0d expected 1", high2[3]);
    end
`endif
  endtask
  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ch[0] = (k < 5) ? 8'd200 : 8'd0;
      tick();
    end
    ch[0] = 8'd200;
    tick();
    checks++;
    if (done_o[0] !== 1'b1 || cnt_o[0] !== 10'd10 || mag_o[0] !== 8'd200) begin
      errors++;
      $display("FAIL midrst_pre done=%b cnt=%0d mag=%0d expected 1/10/200", done_o[0], cnt_o[0], mag_o[0]);
    end
    tick();
    tick();
    res_i = 1'b1;
    ch[0] = 8'd0;
    tick();
    checks++;
    if (done_o[0] !== 1'b0 || cnt_o[0] !== 10'd0 || mag_o[0] !== 8'd0) begin
      errors++;
      $display("FAIL midrst_clear done=%b cnt=%0d mag=%0d expected 0/0/0", done_o[0], cnt_o[0], mag_o[0]);
    end
    res_i = 1'b0;
    tick();
    tick();
    ch[0] = 8'd200;
    tick();
    checks++;
    if (done_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rearm done=%b expected 0", done_o[0]);
    end
    ch[0] = 8'd0;
    for (int k = 0; k < 4; k++) tick();
    ch[0] = 8'd200;
    tick();
    checks++;
    if (done_o[0] !== 1'b1 || cnt_o[0] !== 10'd5 || mag_o[0] !== 8'd200) begin
      errors++;
      $display("FAIL midrst_post done=%b cnt=%0d mag=%0d expected 1/5/200", done_o[0], cnt_o[0], mag_o[0]);
    end
`ifdef SN76489_DET_DUTY_EN
    checks++;
    if (high_o[0] !== 10'd1) begin
      errors++;
      $display("FAIL midrst_high got %0d expected 1", high_o[0]);
    end
`endif
  endtask
  initial begin
    for (int c = 0; c < NUM_CH; c++) ch[c] = '0;
    test_reset();
    test_square();
    test_slow_ce();
    test_timeout();
    test_noise();
    test_thresh();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
